fpu_pipe_arbiter: RTL and testbench

FPU_PIPE_ARBITER -- requirements
Module: fpu_pipe_arbiter

---
 rtl/fpu_pipe_arbiter.sv | 125 ++++++++++++
 tb/tb_fpu_pipe_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe_arbiter.sv
// Two-requester front end for a shared, fixed-depth float pipeline.
// A shadow shift register of {valid, owner} entries advances together with the
// external pipeline, so the block knows which requester each result belongs to.
// Results leave through the tail. A tail result whose owner is not ready stalls
// the whole pipeline, and that stall also blocks new accepts.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// req*_ready never depends on the other requester's ready. resp*_valid stays
// asserted, with stable data, until the owner's resp*_ready is seen high.
//
// STAGES must be at least 2.
module fpu_pipe_arbiter #(
    parameter int STAGES = 6,
    parameter int DW     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic [DW-1:0]                 req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [DW-1:0]                 req1_data,
    output logic                          req1_ready,
    output logic                          pipe_en,
    output logic [DW-1:0]                 pipe_in_data,
    input  logic [DW-1:0]                 pipe_out_data,
    output logic                          resp0_valid,
    input  logic                          resp0_ready,
    output logic [DW-1:0]                 resp0_data,
    output logic                          resp1_valid,
    input  logic                          resp1_ready,
    output logic [DW-1:0]                 resp1_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OW = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [OW-1:0]     occ_q, occ_d;

    logic tail_valid;
    logic tail_owner;
    logic tail_ready;
    logic stall;
    logic consume;
    logic gnt0;
    logic gnt1;
    logic grant;

    // Tail decode: the response ports, the stall condition and the pipeline enable.
    // Reset masks the tail, so no response escapes while in-flight work is discarded.
    always_comb begin
        tail_valid  = valid_q[STAGES-1] && !rst;
        tail_owner  = owner_q[STAGES-1];
        tail_ready  = tail_owner ? resp1_ready : resp0_ready;
        stall       = tail_valid && !tail_ready;
        consume     = tail_valid && tail_ready;
        pipe_en     = !stall;
        resp0_valid = tail_valid && !tail_owner;
        resp1_valid = tail_valid && tail_owner;
        resp0_data  = pipe_out_data;
        resp1_data  = pipe_out_data;
        occupancy   = occ_q;
    end

    // Round-robin grant. Only one grant is given per advancing cycle. No grant is
    // given during reset, because an accept there would be discarded silently.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (pipe_en && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        grant        = gnt0 || gnt1;
        req0_ready   = gnt0;
        req1_ready   = gnt1;
        pipe_in_data = gnt0 ? req0_data : (gnt1 ? req1_data : '0);
    end

    // Next state: shift the shadow register in step with the pipeline.
    // Track the last grant winner and the in-flight count.
    always_comb begin
        valid_d      = valid_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        occ_d        = occ_q;
        if (pipe_en) begin
            valid_d = {valid_q[STAGES-2:0], grant};
            owner_d = {owner_q[STAGES-2:0], gnt1};
        end
        if (grant) begin
            last_grant_d = gnt1;
        end
        case ({grant, consume})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers. Reset empties the shadow pipe and sets last_grant to 1,
    // so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= 1'b1;
            occ_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            occ_q        <= occ_d;
        end
    end

endmodule

// File: tb/tb_fpu_pipe_arbiter.sv
// Bench for fpu_pipe_arbiter. It drives an external data pipeline of the same
// depth and checks against an in-order queue model. Each accepted operand carries
// the advance count at which it entered stage 0. An operand is at the tail once
// STAGES-1 further advances have happened.
module tb_fpu_pipe_arbiter;

    localparam int STAGES = 6;
    localparam int DW     = 32;
    localparam int OW     = $clog2(STAGES + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_data, req1_data;
    logic          pipe_en;
    logic [DW-1:0] pipe_in_data, pipe_out_data;
    logic          resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [DW-1:0] resp0_data, resp1_data;
    logic [OW-1:0] occupancy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fpu_pipe_arbiter #(.STAGES(STAGES), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .pipe_en(pipe_en), .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .occupancy(occupancy)
    );

    // External float pipeline, reset by the same rst and advanced by pipe_en.
    logic [DW-1:0] ext_q [STAGES];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) ext_q[i] <= '0;
        end else if (pipe_en) begin
            ext_q[0] <= pipe_in_data;
            for (int i = 1; i < STAGES; i++) ext_q[i] <= ext_q[i-1];
        end
    end
    assign pipe_out_data = ext_q[STAGES-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        int            tag;
    } op_t;

    op_t  mq[$];
    int   adv_cnt = 0;
    logic m_last  = 1'b1;

    function automatic logic m_tail();
        if (rst || mq.size() == 0) return 1'b0;
        return (adv_cnt - mq[0].tag) == STAGES - 1;
    endfunction

    function automatic logic m_pipe_en();
        if (!m_tail()) return 1'b1;
        return mq[0].owner ? resp1_ready : resp0_ready;
    endfunction

    // Returns -1 for no grant, otherwise the winning requester.
    function automatic int m_grant();
        if (rst || !m_pipe_en()) return -1;
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic m_resp(input logic o);
        if (!m_tail()) return 1'b0;
        return mq[0].owner == o;
    endfunction

    function automatic logic [DW-1:0] m_head_data();
        if (mq.size() == 0) return '0;
        return mq[0].data;
    endfunction

    function automatic logic [DW-1:0] m_in_data();
        int g;
        g = m_grant();
        if (g == 0) return req0_data;
        if (g == 1) return req1_data;
        return '0;
    endfunction

    // Advance the model using the values present before the edge, then move one cycle on.
    task automatic tick();
        int  g;
        op_t op;
        if (rst) begin
            mq.delete();
            m_last = 1'b1;
        end else if (m_pipe_en()) begin
            g = m_grant();
            if (m_tail()) void'(mq.pop_front());
            adv_cnt++;
            if (g >= 0) begin
                op.owner = (g == 1);
                op.data  = (g == 1) ? req1_data : req0_data;
                op.tag   = adv_cnt;
                mq.push_back(op);
                m_last = (g == 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = '0;   req1_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'h1111_1111; req1_data = 32'h2222_2222;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (pipe_en !== 1'b1) begin tests_failed++; $display("FAIL reset_pipe_en: got %b want 1", pipe_en); end
        tests_run++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
        tests_run++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b%b want 00", resp0_valid, resp1_valid); end
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        tick();
        rst = 1'b0;
        set_idle();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL post_reset_occupancy: got %0d want 0", occupancy); end
        tests_run++; if (pipe_en !== 1'b1) begin tests_failed++; $display("FAIL post_reset_pipe_en: got %b want 1", pipe_en); end
        tick();
    endtask

    task automatic test_single_op();
        int lat;
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h3F80_0000;
        @(negedge clk);
        tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL single_accept: got %b want 1", req0_ready); end
        tests_run++; if (pipe_in_data !== 32'h3F80_0000) begin tests_failed++; $display("FAIL single_pipe_in: got %h want 3f800000", pipe_in_data); end
        tick();
        set_idle();
        lat = -1;
        for (int c = 1; c <= STAGES + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests_run++; if (occupancy !== OW'(1)) begin tests_failed++; $display("FAIL single_occ_one: got %0d want 1", occupancy); end
            end
            tests_run++; if (resp1_valid !== 1'b0) begin tests_failed++; $display("FAIL single_resp1_quiet: got %b want 0 at cycle %0d", resp1_valid, c); end
            if (resp0_valid === 1'b1 && lat < 0) begin
                lat = c;
                tests_run++; if (resp0_data !== 32'h3F80_0000) begin tests_failed++; $display("FAIL single_data: got %h want 3f800000", resp0_data); end
            end
            tick();
        end
        tests_run++; if (lat !== STAGES) begin tests_failed++; $display("FAIL single_latency: got %0d want %0d", lat, STAGES); end
        @(negedge clk);
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL single_occ_zero: got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_contention();
        int eg;
        int max_occ;
        int gnt_seq[$];
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        max_occ = 0;
        for (int c = 0; c < 30; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = $urandom; req1_data = $urandom;
            @(negedge clk);
            eg = m_grant();
            tests_run++; if (req0_ready !== (eg == 0) || req1_ready !== (eg == 1)) begin tests_failed++; $display("FAIL cont_grant: got %b%b want grant %0d cycle %0d", req1_ready, req0_ready, eg, c); end
            if (req0_ready === 1'b1) gnt_seq.push_back(0);
            if (req1_ready === 1'b1) gnt_seq.push_back(1);
            tests_run++; if (int'(occupancy) !== mq.size()) begin tests_failed++; $display("FAIL cont_occ: got %0d want %0d", occupancy, mq.size()); end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            tests_run++; if (resp0_valid !== m_resp(1'b0) || resp1_valid !== m_resp(1'b1)) begin tests_failed++; $display("FAIL cont_resp_valid: got %b%b want %b%b", resp1_valid, resp0_valid, m_resp(1'b1), m_resp(1'b0)); end
            if (m_tail()) begin
                tests_run++; if (resp0_data !== m_head_data()) begin tests_failed++; $display("FAIL cont_resp_data: got %h want %h", resp0_data, m_head_data()); end
            end
            if (c >= STAGES) begin
                tests_run++; if ((resp0_valid | resp1_valid) !== 1'b1) begin tests_failed++; $display("FAIL cont_throughput: got no result want one at cycle %0d", c); end
            end
            tick();
        end
        tests_run++; if (gnt_seq.size() < 4 || gnt_seq[0] != 0 || gnt_seq[1] != 1 || gnt_seq[2] != 0 || gnt_seq[3] != 1) begin tests_failed++; $display("FAIL cont_alternate: got %0d grants, want sequence 0,1,0,1 first", gnt_seq.size()); end
        tests_run++; if (max_occ !== STAGES) begin tests_failed++; $display("FAIL cont_saturate: got %0d want %0d", max_occ, STAGES); end
        set_idle();
        for (int c = 0; c < STAGES + 1; c++) tick();
        @(negedge clk);
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL cont_drain: got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_stall();
        logic [DW-1:0] held;
        int results;
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b0;
        for (int c = 0; c < STAGES; c++) begin
            req1_valid = 1'b1; req1_data = $urandom;
            @(negedge clk);
            tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_fill: got %b want 1 at %0d", req1_ready, c); end
            tick();
        end
        held = m_head_data();
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = $urandom; req1_data = $urandom;
            @(negedge clk);
            tests_run++; if (pipe_en !== 1'b0) begin tests_failed++; $display("FAIL stall_pipe_en: got %b want 0", pipe_en); end
            tests_run++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready: got %b%b want 00", req1_ready, req0_ready); end
            tests_run++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_resp_valid: got %b%b want 10", resp1_valid, resp0_valid); end
            tests_run++; if (resp1_data !== held) begin tests_failed++; $display("FAIL stall_data_stable: got %h want %h", resp1_data, held); end
            tests_run++; if (int'(occupancy) !== STAGES) begin tests_failed++; $display("FAIL stall_occ: got %0d want %0d", occupancy, STAGES); end
            tick();
        end
        set_idle();
        resp1_ready = 1'b1;
        results = 0;
        for (int c = 0; c < STAGES + 2; c++) begin
            @(negedge clk);
            tests_run++; if (resp1_valid !== m_resp(1'b1)) begin tests_failed++; $display("FAIL stall_resume_valid: got %b want %b", resp1_valid, m_resp(1'b1)); end
            if (resp1_valid === 1'b1) begin
                results++;
                tests_run++; if (resp1_data !== m_head_data()) begin tests_failed++; $display("FAIL stall_resume_data: got %h want %h", resp1_data, m_head_data()); end
            end
            tick();
        end
        tests_run++; if (results !== STAGES) begin tests_failed++; $display("FAIL stall_no_loss: got %0d results want %0d", results, STAGES); end
    endtask

    task automatic test_bubbles();
        int last_resp;
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        last_resp = -1;
        for (int c = 0; c < 36; c++) begin
            set_idle();
            if (c % 3 == 0) begin
                if ($urandom_range(0, 1) == 0) begin req0_valid = 1'b1; req0_data = $urandom; end
                else begin req1_valid = 1'b1; req1_data = $urandom; end
            end
            @(negedge clk);
            tests_run++; if (occupancy > OW'(2)) begin tests_failed++; $display("FAIL bubble_occ: got %0d want <=2", occupancy); end
            tests_run++; if (resp0_valid !== m_resp(1'b0) || resp1_valid !== m_resp(1'b1)) begin tests_failed++; $display("FAIL bubble_resp_valid: got %b%b want %b%b", resp1_valid, resp0_valid, m_resp(1'b1), m_resp(1'b0)); end
            if ((resp0_valid | resp1_valid) === 1'b1) begin
                if (last_resp >= 0) begin
                    tests_run++; if (c - last_resp != 3) begin tests_failed++; $display("FAIL bubble_spacing: got %0d want 3", c - last_resp); end
                end
                last_resp = c;
                tests_run++; if (resp0_data !== m_head_data()) begin tests_failed++; $display("FAIL bubble_data: got %h want %h", resp0_data, m_head_data()); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_idle();
            if (c % 2 == 0) begin req0_valid = 1'b1; req0_data = $urandom; end
            else begin req1_valid = 1'b1; req1_data = $urandom; end
            tick();
        end
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_during: got %b%b want 00", resp1_valid, resp0_valid); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < STAGES + 2; c++) begin
            @(negedge clk);
            tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL midrst_occ: got %0d want 0", occupancy); end
            tests_run++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_resp: got %b%b want 00", resp1_valid, resp0_valid); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int eg;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req0_valid  = ($urandom_range(0, 3) != 0);
            req1_valid  = ($urandom_range(0, 3) != 0);
            req0_data   = $urandom;
            req1_data   = $urandom;
            resp0_ready = ($urandom_range(0, 4) != 0);
            resp1_ready = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            eg = m_grant();
            tests_run++; if (pipe_en !== m_pipe_en()) begin tests_failed++; $display("FAIL rand_pipe_en: got %b want %b", pipe_en, m_pipe_en()); end
            tests_run++; if (req0_ready !== (eg == 0) || req1_ready !== (eg == 1)) begin tests_failed++; $display("FAIL rand_grant: got %b%b want grant %0d", req1_ready, req0_ready, eg); end
            tests_run++; if (pipe_in_data !== m_in_data()) begin tests_failed++; $display("FAIL rand_pipe_in: got %h want %h", pipe_in_data, m_in_data()); end
            tests_run++; if (resp0_valid !== m_resp(1'b0) || resp1_valid !== m_resp(1'b1)) begin tests_failed++; $display("FAIL rand_owner: got %b%b want %b%b", resp1_valid, resp0_valid, m_resp(1'b1), m_resp(1'b0)); end
            if (m_tail()) begin
                tests_run++; if (resp1_data !== m_head_data()) begin tests_failed++; $display("FAIL rand_data: got %h want %h", resp1_data, m_head_data()); end
            end
            tests_run++; if (int'(occupancy) !== mq.size()) begin tests_failed++; $display("FAIL rand_occ: got %0d want %0d", occupancy, mq.size()); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        test_reset();
        test_single_op();
        test_contention();
        test_stall();
        test_bubbles();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
